// File: rtl/sha_tag_checker_pkg.sv
// Shared definitions for the receive-side HMAC tag checker.
//   state_t    : checker FSM states
//   ST_*       : bit positions inside the status beat
//   TAG_W      : width of the digest / tag field
package sha_tag_checker_pkg;

  localparam int TAG_W     = 256;

  localparam int ST_PASS   = 0;
  localparam int ST_MARK   = 1;
  localparam int ST_EMPTY  = 2;
  localparam int ST_IDERR  = 3;
  localparam int ST_CNT_LO = 32;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HOLD     = 2'd1,
    S_WAIT_DIG = 2'd2,
    S_STATUS   = 2'd3
  } state_t;

endpackage

// File: rtl/sha_tag_checker_axis_fork_reg.sv
// Single-entry register feeding two stream sinks with independent valids.
//   clock, reset        : clock / async active-high reset
//   load                : capture in_* and raise both valids (only when free)
//   in_data/keep/id/last: beat to capture; in_last is presented on side a only
//   free                : both sides empty or emptying this cycle
//   a_valid/a_ready/a_last : side a handshake (hash copy)
//   b_valid/b_ready        : side b handshake (forwarded payload)
//   data/keep/id        : registered beat shared by both sides
module axis_fork_reg #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = 64,
  parameter int ID_W   = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic [ID_W-1:0]   in_id,
  input  logic              in_last,
  output logic              free,
  output logic              a_valid,
  input  logic              a_ready,
  output logic              a_last,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [DATA_W-1:0] data,
  output logic [KEEP_W-1:0] keep,
  output logic [ID_W-1:0]   id
);

  assign free = (!a_valid || a_ready) && (!b_valid || b_ready);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_valid <= 1'b0;
      b_valid <= 1'b0;
      a_last  <= 1'b0;
      data    <= '0;
      keep    <= '0;
      id      <= '0;
    end else if (load) begin
      a_valid <= 1'b1;
      b_valid <= 1'b1;
      a_last  <= in_last;
      data    <= in_data;
      keep    <= in_keep;
      id      <= in_id;
    end else begin
      if (a_ready) a_valid <= 1'b0;
      if (b_ready) b_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sha_tag_checker.sv
// Receive-side HMAC tag checker. Forwards payload beats, streams a copy to the
// hmac core with last moved onto the final payload beat, compares the returned
// digest with the received tag and replaces the tag beat with a status beat.
//   clock, reset : clock / async active-high reset
//   inp_*        : packet stream in (inp_last marks the tag beat)
//   hsh_*        : payload copy to the hmac core
//   dig_*        : digest from the hmac core (dig_data[255:0] used)
//   out_*        : payload followed by the status beat
//
// state      | meaning
// S_IDLE     | hold register empty, waiting for first beat of a packet
// S_HOLD     | one payload beat held until the next beat shows if it was final
// S_WAIT_DIG | tag captured, waiting for hash copy to drain and digest to return
// S_STATUS   | presenting the status beat on out
module sha_tag_checker
  import sha_tag_checker_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int KEEP_W = 64,
  parameter int ID_W   = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inp_valid,
  output logic              inp_ready,
  input  logic [DATA_W-1:0] inp_data,
  input  logic [KEEP_W-1:0] inp_keep,
  input  logic [ID_W-1:0]   inp_id,
  input  logic              inp_last,
  output logic              hsh_valid,
  input  logic              hsh_ready,
  output logic [DATA_W-1:0] hsh_data,
  output logic [KEEP_W-1:0] hsh_keep,
  output logic [ID_W-1:0]   hsh_id,
  output logic              hsh_last,
  input  logic              dig_valid,
  output logic              dig_ready,
  input  logic [DATA_W-1:0] dig_data,
  input  logic [KEEP_W-1:0] dig_keep,
  input  logic [ID_W-1:0]   dig_id,
  input  logic              dig_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic [ID_W-1:0]   out_id,
  output logic              out_last
);

  state_t            state;
  logic [DATA_W-1:0] hold_data;
  logic [KEEP_W-1:0] hold_keep;
  logic [ID_W-1:0]   hold_id;
  logic [TAG_W-1:0]  tag;
  logic [ID_W-1:0]   pkt_id;
  logic              id_err;
  logic              empty_pkt;
  logic              pass;
  logic [15:0]       cnt;

  logic              free;
  logic              acc;
  logic              load;
  logic              dig_acc;
  logic              stat_acc;
  logic              fork_out_valid;
  logic [DATA_W-1:0] fork_data;
  logic [KEEP_W-1:0] fork_keep;
  logic [ID_W-1:0]   fork_id;
  logic [DATA_W-1:0] status_word;
  logic              in_status;
  logic              unused_dig;

  assign unused_dig = ^{dig_keep, dig_id, dig_last, dig_data[DATA_W-1:TAG_W]};

  assign in_status = (state == S_STATUS);
  assign inp_ready = !reset && ((state == S_IDLE) || (state == S_HOLD)) && free;
  assign acc       = inp_valid && inp_ready;
  assign load      = acc && (state == S_HOLD);
  // Digest is only taken once the final hash beat has left, so the hmac core
  // has seen the whole packet.
  assign dig_ready = (state == S_WAIT_DIG) && !hsh_valid;
  assign dig_acc   = dig_valid && dig_ready;
  // Pending payload on out always drains before the status beat is shown.
  assign stat_acc  = in_status && !fork_out_valid && out_ready;

  axis_fork_reg #(
    .DATA_W(DATA_W),
    .KEEP_W(KEEP_W),
    .ID_W  (ID_W)
  ) u_fork (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .in_data(hold_data),
    .in_keep(hold_keep),
    .in_id  (hold_id),
    .in_last(inp_last),
    .free   (free),
    .a_valid(hsh_valid),
    .a_ready(hsh_ready),
    .a_last (hsh_last),
    .b_valid(fork_out_valid),
    .b_ready(out_ready),
    .data   (fork_data),
    .keep   (fork_keep),
    .id     (fork_id)
  );

  assign hsh_data = fork_data;
  assign hsh_keep = fork_keep;
  assign hsh_id   = fork_id;

  always_comb begin
    status_word                           = '0;
    status_word[ST_PASS]                  = pass;
    status_word[ST_MARK]                  = 1'b1;
    status_word[ST_EMPTY]                 = empty_pkt;
    status_word[ST_IDERR]                 = id_err;
    status_word[ST_CNT_LO+15:ST_CNT_LO]   = cnt;
  end

  assign out_valid = fork_out_valid || in_status;
  assign out_data  = (!fork_out_valid && in_status) ? status_word : fork_data;
  assign out_keep  = (!fork_out_valid && in_status) ? {KEEP_W{1'b1}} : fork_keep;
  assign out_id    = (!fork_out_valid && in_status) ? pkt_id : fork_id;
  assign out_last  = !fork_out_valid && in_status;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      hold_data <= '0;
      hold_keep <= '0;
      hold_id   <= '0;
      tag       <= '0;
      pkt_id    <= '0;
      id_err    <= 1'b0;
      empty_pkt <= 1'b0;
      pass      <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: if (acc) begin
          pkt_id <= inp_id;
          id_err <= 1'b0;
          if (inp_last) begin
            tag       <= inp_data[TAG_W-1:0];
            empty_pkt <= 1'b1;
            pass      <= 1'b0;
            cnt       <= '0;
            state     <= S_STATUS;
          end else begin
            hold_data <= inp_data;
            hold_keep <= inp_keep;
            hold_id   <= inp_id;
            empty_pkt <= 1'b0;
            cnt       <= 16'd1;
            state     <= S_HOLD;
          end
        end
        S_HOLD: if (acc) begin
          if (inp_id != pkt_id) id_err <= 1'b1;
          if (inp_last) begin
            tag   <= inp_data[TAG_W-1:0];
            state <= S_WAIT_DIG;
          end else begin
            hold_data <= inp_data;
            hold_keep <= inp_keep;
            hold_id   <= inp_id;
            if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
          end
        end
        S_WAIT_DIG: if (dig_acc) begin
          pass  <= (dig_data[TAG_W-1:0] == tag) && !id_err;
          state <= S_STATUS;
        end
        S_STATUS: if (stat_acc) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_tag_checker.sv
module tb_sha_tag_checker;
  localparam int DATA_W = 512;
  localparam int KEEP_W = 64;
  localparam int ID_W   = 6;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic [ID_W-1:0]   id;
    logic              last;
  } beat_t;

  logic clock = 1'b0;
  logic reset;
  logic inp_valid, inp_ready, inp_last;
  logic [DATA_W-1:0] inp_data;
  logic [KEEP_W-1:0] inp_keep;
  logic [ID_W-1:0]   inp_id;
  logic hsh_valid, hsh_ready, hsh_last;
  logic [DATA_W-1:0] hsh_data;
  logic [KEEP_W-1:0] hsh_keep;
  logic [ID_W-1:0]   hsh_id;
  logic dig_valid, dig_ready, dig_last;
  logic [DATA_W-1:0] dig_data;
  logic [KEEP_W-1:0] dig_keep;
  logic [ID_W-1:0]   dig_id;
  logic out_valid, out_ready, out_last;
  logic [DATA_W-1:0] out_data;
  logic [KEEP_W-1:0] out_keep;
  logic [ID_W-1:0]   out_id;

  always #5 clock = ~clock;

  sha_tag_checker #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .ID_W(ID_W)) dut (
    .clock(clock), .reset(reset),
    .inp_valid(inp_valid), .inp_ready(inp_ready), .inp_data(inp_data),
    .inp_keep(inp_keep), .inp_id(inp_id), .inp_last(inp_last),
    .hsh_valid(hsh_valid), .hsh_ready(hsh_ready), .hsh_data(hsh_data),
    .hsh_keep(hsh_keep), .hsh_id(hsh_id), .hsh_last(hsh_last),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data),
    .dig_keep(dig_keep), .dig_id(dig_id), .dig_last(dig_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_id(out_id), .out_last(out_last)
  );

  int tests_run = 0;
  int tests_failed = 0;

  beat_t in_pl[$];
  beat_t in_tag;
  logic [DATA_W-1:0] dig_value;
  beat_t obs_hsh[$], obs_out[$], exp_hsh[$], exp_out[$];
  int hsh_mode, out_mode, lo_start, lo_len, dig_delay, gap_max;
  int viol, dig_hi, cyc, dig_cyc, stat_cyc, seen_cyc;
  bit done, timed_out, hsh_last_seen, dig_taken;

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic make_packet(input int n, input logic [ID_W-1:0] id);
    beat_t b;
    in_pl.delete();
    for (int i = 0; i < n; i++) begin
      b = {rnd_data(), {$urandom, $urandom}, id, 1'b0};
      in_pl.push_back(b);
    end
    in_tag = {rnd_data(), {$urandom, $urandom}, id, 1'b1};
    dig_value = rnd_data();
    dig_value[255:0] = in_tag.data[255:0];
  endtask

  task automatic set_env(input int h, input int o, input int d, input int g);
    hsh_mode = h; out_mode = o; dig_delay = d; gap_max = g;
    lo_start = 0; lo_len = 0;
  endtask

  // Packet-level reference: what the two sinks must see for the current packet.
  task automatic build_expected();
    logic [ID_W-1:0] pid;
    logic [DATA_W-1:0] st;
    bit ierr, ok;
    int n;
    beat_t b;
    exp_hsh.delete(); exp_out.delete();
    n = in_pl.size();
    pid = (n > 0) ? in_pl[0].id : in_tag.id;
    ierr = (in_tag.id != pid);
    foreach (in_pl[i]) if (in_pl[i].id != pid) ierr = 1;
    foreach (in_pl[i]) begin
      b = in_pl[i];
      b.last = (i == n - 1);
      exp_hsh.push_back(b);
      b.last = 1'b0;
      exp_out.push_back(b);
    end
    ok = (n > 0) && (dig_value[255:0] == in_tag.data[255:0]) && !ierr;
    st = '0;
    st[0] = ok;
    st[1] = 1'b1;
    st[2] = (n == 0);
    st[3] = ierr;
    st[47:32] = (n > 65535) ? 16'hFFFF : 16'(n);
    b = {st, {KEEP_W{1'b1}}, pid, 1'b1};
    exp_out.push_back(b);
  endtask

  // Drives one packet and collects what both sinks accept. Called right after a
  // rising edge; returns shortly after a rising edge.
  task automatic run_packet();
    beat_t all[$];
    int g, k;
    bit acc;
    obs_hsh.delete(); obs_out.delete();
    viol = 0; dig_hi = 0; cyc = 0; dig_cyc = -1; stat_cyc = -1; seen_cyc = 0;
    done = 0; timed_out = 0; hsh_last_seen = 0; dig_taken = 0;
    all = in_pl;
    all.push_back(in_tag);
    k = 0;
    fork
      begin
        foreach (all[i]) begin
          if (done) break;
          g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
          repeat (g) begin @(posedge clock); #1; end
          {inp_data, inp_keep, inp_id, inp_last} = all[i];
          inp_valid = 1'b1;
          do begin
            @(negedge clock);
            acc = inp_ready;
            @(posedge clock); #1;
          end while (!acc && !done);
          inp_valid = 1'b0;
        end
      end
      begin
        while (!done) begin
          @(negedge clock);
          cyc++;
          if (hsh_valid && hsh_ready) begin
            obs_hsh.push_back(beat_t'({hsh_data, hsh_keep, hsh_id, hsh_last}));
            if (hsh_last) begin hsh_last_seen = 1; seen_cyc = cyc; end
          end
          if (out_valid && out_last && stat_cyc < 0) stat_cyc = cyc;
          if (dig_valid && dig_ready) begin dig_taken = 1; dig_cyc = cyc; end
          if (dig_ready) dig_hi++;
          if (inp_ready && ((hsh_valid && !hsh_ready) || (out_valid && !out_ready))) viol++;
          if (dig_ready && hsh_valid) viol++;
          if (out_valid && out_ready) begin
            obs_out.push_back(beat_t'({out_data, out_keep, out_id, out_last}));
            if (out_last) done = 1;
          end
          if (cyc > 2000) begin timed_out = 1; done = 1; end
        end
      end
      begin
        while (!done) begin
          case (hsh_mode)
            0: hsh_ready = 1'b1;
            1: hsh_ready = 1'($urandom_range(1, 0));
            default: hsh_ready = !(k >= lo_start && k < lo_start + lo_len);
          endcase
          case (out_mode)
            0: out_ready = 1'b1;
            1: out_ready = k[0];
            default: out_ready = 1'($urandom_range(1, 0));
          endcase
          if (dig_valid && dig_taken) dig_valid = 1'b0;
          else if (!dig_valid && hsh_last_seen && !dig_taken && cyc >= seen_cyc + dig_delay) begin
            dig_valid = 1'b1;
            dig_data = dig_value;
            dig_keep = {$urandom, $urandom};
            dig_id = ID_W'($urandom);
            dig_last = 1'($urandom_range(1, 0));
          end
          @(posedge clock); #1;
          k++;
        end
      end
    join
    dig_valid = 1'b0;
    hsh_ready = 1'b1;
    out_ready = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    tests_run++;
    if ({inp_ready, hsh_valid, out_valid, dig_ready} !== 4'b0) begin
      tests_failed++;
      $display("FAIL reset_handshake got inp_ready/hsh_valid/out_valid/dig_ready=%b required 0000",
               {inp_ready, hsh_valid, out_valid, dig_ready});
    end
    tests_run++;
    if ({hsh_last, out_last, hsh_id, out_id, hsh_keep, out_keep} !== '0) begin
      tests_failed++;
      $display("FAIL reset_ctrl got last=%b%b id=%h/%h keep=%h/%h required all 0",
               hsh_last, out_last, hsh_id, out_id, hsh_keep, out_keep);
    end
    tests_run++;
    if ((hsh_data !== '0) || (out_data !== '0)) begin
      tests_failed++;
      $display("FAIL reset_data got hsh=%h out=%h required 0", hsh_data[63:0], out_data[63:0]);
    end
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    tests_run++;
    if (inp_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready got %b required 1", inp_ready);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_match();
    make_packet(4, 6'd3);
    set_env(0, 0, 0, 0);
    run_packet();
    build_expected();
    tests_run++;
    if ((obs_hsh.size() != 4) || (obs_out.size() != 5) || timed_out) begin
      tests_failed++;
      $display("FAIL match_count got hsh=%0d out=%0d timeout=%0d required 4 5 0",
               obs_hsh.size(), obs_out.size(), timed_out);
    end
    foreach (exp_hsh[i]) if (i < obs_hsh.size()) begin
      tests_run++;
      if (obs_hsh[i] !== exp_hsh[i]) begin
        tests_failed++;
        $display("FAIL match_hsh[%0d] got d=%h id=%h last=%b required d=%h id=%h last=%b", i,
                 obs_hsh[i].data[63:0], obs_hsh[i].id, obs_hsh[i].last,
                 exp_hsh[i].data[63:0], exp_hsh[i].id, exp_hsh[i].last);
      end
    end
    foreach (exp_out[i]) if (i < obs_out.size()) begin
      tests_run++;
      if (obs_out[i] !== exp_out[i]) begin
        tests_failed++;
        $display("FAIL match_out[%0d] got d=%h id=%h last=%b required d=%h id=%h last=%b", i,
                 obs_out[i].data[63:0], obs_out[i].id, obs_out[i].last,
                 exp_out[i].data[63:0], exp_out[i].id, exp_out[i].last);
      end
    end
    tests_run++;
    if (stat_cyc != dig_cyc + 1 || dig_cyc < 0) begin
      tests_failed++;
      $display("FAIL match_status_latency got status cycle %0d digest cycle %0d required status = digest+1",
               stat_cyc, dig_cyc);
    end
  endtask

  task automatic test_mismatch();
    make_packet(4, 6'd3);
    in_tag.data[17] = ~in_tag.data[17];
    set_env(0, 0, 2, 0);
    run_packet();
    build_expected();
    tests_run++;
    if (obs_out.size() != 5 || timed_out) begin
      tests_failed++;
      $display("FAIL mismatch_count got out=%0d timeout=%0d required 5 0", obs_out.size(), timed_out);
    end else begin
      tests_run++;
      if (obs_out[4] !== exp_out[4]) begin
        tests_failed++;
        $display("FAIL mismatch_status got d=%h required d=%h", obs_out[4].data[63:0], exp_out[4].data[63:0]);
      end
    end
  endtask

  task automatic test_empty();
    make_packet(0, 6'd9);
    set_env(0, 0, 0, 0);
    run_packet();
    build_expected();
    tests_run++;
    if (obs_hsh.size() != 0 || dig_hi != 0 || obs_out.size() != 1 || timed_out) begin
      tests_failed++;
      $display("FAIL empty_counts got hsh=%0d dig_ready_cycles=%0d out=%0d timeout=%0d required 0 0 1 0",
               obs_hsh.size(), dig_hi, obs_out.size(), timed_out);
    end
    if (obs_out.size() > 0) begin
      tests_run++;
      if (obs_out[0] !== exp_out[0]) begin
        tests_failed++;
        $display("FAIL empty_status got d=%h id=%h keep=%h required d=%h id=%h keep=%h",
                 obs_out[0].data[63:0], obs_out[0].id, obs_out[0].keep,
                 exp_out[0].data[63:0], exp_out[0].id, exp_out[0].keep);
      end
    end
  endtask

  task automatic test_backpressure();
    int nstat;
    make_packet(6, 6'd12);
    set_env(2, 1, 20, 0);
    lo_start = 3; lo_len = 10;
    run_packet();
    build_expected();
    tests_run++;
    if (obs_hsh.size() != exp_hsh.size() || obs_out.size() != exp_out.size() || timed_out) begin
      tests_failed++;
      $display("FAIL bp_count got hsh=%0d out=%0d timeout=%0d required %0d %0d 0",
               obs_hsh.size(), obs_out.size(), timed_out, exp_hsh.size(), exp_out.size());
    end
    foreach (exp_hsh[i]) if (i < obs_hsh.size()) begin
      tests_run++;
      if (obs_hsh[i] !== exp_hsh[i]) begin
        tests_failed++;
        $display("FAIL bp_hsh[%0d] got d=%h last=%b required d=%h last=%b", i,
                 obs_hsh[i].data[63:0], obs_hsh[i].last, exp_hsh[i].data[63:0], exp_hsh[i].last);
      end
    end
    foreach (exp_out[i]) if (i < obs_out.size()) begin
      tests_run++;
      if (obs_out[i] !== exp_out[i]) begin
        tests_failed++;
        $display("FAIL bp_out[%0d] got d=%h last=%b required d=%h last=%b", i,
                 obs_out[i].data[63:0], obs_out[i].last, exp_out[i].data[63:0], exp_out[i].last);
      end
    end
    tests_run++;
    if (viol != 0) begin
      tests_failed++;
      $display("FAIL bp_ready_while_blocked got %0d violating cycles required 0", viol);
    end
    nstat = 0;
    foreach (obs_out[i]) if (obs_out[i].last) nstat++;
    tests_run++;
    if (nstat != 1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_one_status got %0d status beats out_valid_after=%b required 1 0", nstat, out_valid);
    end
  endtask

  task automatic test_id_err();
    beat_t b;
    make_packet(4, 6'd3);
    b = in_pl[1];
    b.id = 6'd5;
    in_pl[1] = b;
    set_env(0, 0, 0, 0);
    run_packet();
    build_expected();
    tests_run++;
    if (obs_hsh.size() != 4 || obs_out.size() != 5 || timed_out) begin
      tests_failed++;
      $display("FAIL iderr_count got hsh=%0d out=%0d timeout=%0d required 4 5 0",
               obs_hsh.size(), obs_out.size(), timed_out);
    end else begin
      tests_run++;
      if (obs_hsh[1] !== exp_hsh[1] || obs_out[1] !== exp_out[1]) begin
        tests_failed++;
        $display("FAIL iderr_forward got hsh id=%h out id=%h required %h",
                 obs_hsh[1].id, obs_out[1].id, exp_out[1].id);
      end
      tests_run++;
      if (obs_out[4] !== exp_out[4]) begin
        tests_failed++;
        $display("FAIL iderr_status got d=%h id=%h required d=%h id=%h",
                 obs_out[4].data[63:0], obs_out[4].id, exp_out[4].data[63:0], exp_out[4].id);
      end
    end
  endtask

  task automatic test_reset_mid();
    make_packet(6, 6'd7);
    hsh_ready = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      {inp_data, inp_keep, inp_id, inp_last} = in_pl[i];
      inp_valid = 1'b1;
      @(posedge clock); #1;
    end
    inp_valid = 1'b0;
    tests_run++;
    if ({hsh_valid, out_valid} !== 2'b11) begin
      tests_failed++;
      $display("FAIL rstmid_pre got hsh_valid/out_valid=%b required 11", {hsh_valid, out_valid});
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({inp_ready, hsh_valid, out_valid, dig_ready} !== 4'b0) begin
      tests_failed++;
      $display("FAIL rstmid_clear got inp_ready/hsh_valid/out_valid/dig_ready=%b required 0000",
               {inp_ready, hsh_valid, out_valid, dig_ready});
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    make_packet(3, 6'd8);
    set_env(0, 0, 1, 0);
    run_packet();
    build_expected();
    tests_run++;
    if (obs_hsh.size() != 3 || obs_out.size() != 4 || timed_out) begin
      tests_failed++;
      $display("FAIL rstmid_count got hsh=%0d out=%0d timeout=%0d required 3 4 0",
               obs_hsh.size(), obs_out.size(), timed_out);
    end else begin
      tests_run++;
      if (obs_out[0] !== exp_out[0] || obs_out[3] !== exp_out[3]) begin
        tests_failed++;
        $display("FAIL rstmid_after got first=%h status=%h required first=%h status=%h",
                 obs_out[0].data[63:0], obs_out[3].data[63:0], exp_out[0].data[63:0], exp_out[3].data[63:0]);
      end
    end
  endtask

  task automatic test_random();
    beat_t b;
    int n, bad;
    for (int p = 0; p < 12; p++) begin
      n = int'($urandom_range(6, 0));
      make_packet(n, ID_W'($urandom));
      if (n > 1 && $urandom_range(3, 0) == 0) begin
        int j;
        j = int'($urandom_range(n - 1, 1));
        b = in_pl[j];
        b.id = b.id ^ 6'd1;
        in_pl[j] = b;
      end
      if ($urandom_range(2, 0) == 0) begin
        int j;
        j = int'($urandom_range(255, 0));
        dig_value[j] = ~dig_value[j];
      end
      set_env(1, 2, int'($urandom_range(5, 0)), 2);
      run_packet();
      build_expected();
      bad = 0;
      foreach (exp_out[i]) if (i >= obs_out.size() || obs_out[i] !== exp_out[i]) bad++;
      foreach (exp_hsh[i]) if (i >= obs_hsh.size() || obs_hsh[i] !== exp_hsh[i]) bad++;
      tests_run++;
      if (bad != 0 || obs_out.size() != exp_out.size() || obs_hsh.size() != exp_hsh.size() ||
          viol != 0 || timed_out) begin
        tests_failed++;
        $display("FAIL random[%0d] got %0d bad beats hsh=%0d out=%0d viol=%0d timeout=%0d required 0 %0d %0d 0 0",
                 p, bad, obs_hsh.size(), obs_out.size(), viol, timed_out, exp_hsh.size(), exp_out.size());
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    inp_valid = 1'b0; inp_data = '0; inp_keep = '0; inp_id = '0; inp_last = 1'b0;
    hsh_ready = 1'b0; out_ready = 1'b0;
    dig_valid = 1'b0; dig_data = '0; dig_keep = '0; dig_id = '0; dig_last = 1'b0;
    test_reset();
    test_match();
    test_mismatch();
    test_empty();
    test_backpressure();
    test_id_err();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sha_tag_checker.md
# sha_tag_checker

Receive-side counterpart of the HMAC tag-insertion path. Incoming packets are payload beats followed by one tag beat, whose low 256 bits carry the HMAC digest. The block forwards the payload unchanged and streams a copy to the external `hmac` core with `last` moved onto the final payload beat. It then compares the returned digest against the received tag and replaces the tag beat with a status beat. It sits between the host/network ingress FIFO and the downstream consumer, alongside one `hmac` instance and its output FIFO.

## Interface
- `DATA_W`, 512: beat data width.
- `KEEP_W`, 64: `DATA_W/8`.
- `ID_W`, 6: stream id width.
- `clock`  in  1  sole clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-high; all state cleared immediately.
- `inp_valid/inp_ready/inp_data/inp_keep/inp_id/inp_last`  in/out/in/in/in/in  1/1/DATA_W/KEEP_W/ID_W/1  packet stream; `inp_last` marks the tag beat.
- `hsh_valid/hsh_ready/hsh_data/hsh_keep/hsh_id/hsh_last`  out/in/out/out/out/out  same widths  payload copy to the `hmac` core.
- `dig_valid/dig_ready/dig_data/dig_keep/dig_id/dig_last`  in/out/in/in/in/in  same widths  digest beat from the `hmac` core; only `dig_data[255:0]` is used.
- `out_valid/out_ready/out_data/out_keep/out_id/out_last`  out/in/out/out/out/out  same widths  payload followed by the status beat.

## Operation
- Handshake convention:
  - A transfer occurs when valid && ready.
  - Once asserted, a valid and its payload stay stable until accepted.
- One-beat lookahead: the hold register keeps the most recent payload beat until the next input beat reveals whether it was the final one.
- States: IDLE (hold empty), HOLD (one payload beat held), WAIT_DIG, STATUS.
- IDLE:
  - Non-last input beat: goes to hold; go to HOLD.
  - Last (tag) input beat: empty packet; capture the tag, skip hashing, go to STATUS.
- HOLD, on accept:
  - The held beat loads both output registers: `hsh_last`=`out_last`=0.
  - The new beat, if non-last, replaces it in hold.
  - If the new beat is the tag, the tag is captured, `hsh_last`=1 for the held beat, and the state goes to WAIT_DIG.
- WAIT_DIG:
  - `dig_ready`=1 only here and only once `hsh_valid`=0.
  - On the digest handshake, `pass` = (`dig_data[255:0]` == `tag[255:0]`) && !`id_err`; go to STATUS.
  - `dig_last` and `dig_keep` are ignored.
- STATUS:
  - Drive one beat on `out` with `out_last`=1, `out_keep`=all ones and `out_id`=packet id.
  - Status beat data: bit0 pass, bit1 1 (status marker), bit2 empty_pkt, bit3 id_err, bits[47:32] payload beat count, all other bits 0.
  - On accept, go to IDLE.
- Packet id:
  - Taken from the first beat.
  - `id_err` is set if any later beat, including the tag, has a different id; beats are forwarded regardless.
- Beat count: 16-bit, saturates at 0xFFFF, cleared at packet start.
- Forwarding rules:
  - Payload `data`, `keep` and `id` are forwarded bit-exact on both `hsh` and `out`.
  - The tag beat never appears on `hsh` or `out`.
- Reset mid-packet: the partial packet is discarded with no status beat, and the next packet starts in IDLE.

## Timing
- Reset values:
  - All valids and readies are 0.
  - All data, keep, id and last outputs are 0.
  - State is IDLE.
- `inp_ready` = (IDLE or HOLD) && (!`hsh_valid` || `hsh_ready`) && (!`out_valid` || `out_ready`); it is 0 in WAIT_DIG and STATUS.
- `hsh` and `out` are separate output registers with independent valids. A beat loaded into both clears each valid on its own handshake, and the next load waits for both (fork semantics).
- Throughput is one beat per cycle with both sinks ready.
- Payload beat k appears on `hsh`/`out` in the cycle after beat k+1 (or the tag) is accepted.
- Status beat: `out_valid` rises the cycle after the digest handshake, or the cycle after tag acceptance for an empty packet.
- No combinational path from `hsh_ready`/`out_ready` to the output valids; the only combinational ready path is `inp_ready`.

## Structure
- Shared package holds:
  - the state enum;
  - the status bit positions (`ST_PASS`=0, `ST_MARK`=1, `ST_EMPTY`=2, `ST_IDERR`=3, `ST_CNT_LO`=32);
  - `TAG_W`=256.
- One natural sub-module, `axis_fork_reg`: a single input register feeding two outputs with independent valid/ready and a both-taken indication. The top level adds the lookahead, FSM and compare logic.

## Test plan
- Matching digest: 4 payload beats, id 3, + tag equal to the digest.
  - `hsh`: 4 beats, `last` only on beat 4.
  - `out`: 4 payload beats + status `data[1:0]`=2'b11, `data[47:32]`=4, `out_last` on the status beat only.
- Mismatch: same packet with tag bit 17 flipped -> status bit0=0, bit1=1, count 4.
- Empty packet: tag-only packet -> zero `hsh` beats, `dig_ready` never high, status `data[2]`=1, bit0=0, count 0.
- Backpressure with delayed digest:
  - Stimulus: `hsh_ready` low for 10 cycles mid-packet, `out_ready` toggling every cycle, digest returned 20 cycles late.
  - Response: no lost or duplicated beats, `inp_ready`=0 while blocked, exactly one status beat.
- Id error: beat 2 carries id 5 in an id-3 packet -> status bit3=1, bit0=0 even with a matching digest.
- Reset mid-packet: reset after 2 of 6 beats.
  - All valids are 0 immediately.
  - A following 3-beat matching packet verifies with pass=1 and count 3.
